// File: rtl/bandeja_rolhas_pkg.sv
// Shared definitions for the cork tray and its dispenser: FSM encoding and tray defaults.
// The dispenser block refills in units of LOTE_PADRAO corks, so both sides must agree on it.
package bandeja_rolhas_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        PEDINDO     = 2'd1,
        ESPERA      = 2'd2,
        SEM_ESTOQUE = 2'd3
    } estado_t;

    localparam int CAPACIDADE_PADRAO = 25;
    localparam int LOTE_PADRAO       = 20;
    localparam int LIMIAR_PADRAO     = 5;
    localparam int TIMEOUT_PADRAO    = 4;

    // Clamp a widened sum back to the tray capacity.
    function automatic logic [5:0] saturar(input logic [5:0] soma, input logic [5:0] teto);
        return (soma > teto) ? teto : soma;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Handshake watchdog: counts enabled cycles, flags the cycle in which the count reaches LIMITE.
// Latency: atingiu is combinational on the enabled cycle; clear has priority over enable.
module contador_timeout #(
    parameter int LIMITE = 4,
    parameter int W      = $clog2(LIMITE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic limpar,
    input  logic habilitar,
    output logic atingiu
);

    localparam logic [W-1:0] ULTIMO = W'(LIMITE - 1);
    localparam logic [W-1:0] TOPO   = W'(LIMITE);

    logic [W-1:0] contagem;

    assign atingiu = habilitar && !limpar && (contagem == ULTIMO);

    always_ff @(posedge clk) begin
        if (rst || limpar) begin
            contagem <= '0;
        end else if (habilitar && (contagem != TOPO)) begin
            contagem <= contagem + 1'b1;
        end
    end

endmodule

// File: rtl/bandeja_rolhas.sv
// Cork tray: tracks stock, requests refills below LIMIAR, one batch per grant, sticky no-stock flag.
// Latency: count, ativar and flags are registered and change the cycle after the causing input.
module bandeja_rolhas
    import bandeja_rolhas_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int CAPACIDADE = CAPACIDADE_PADRAO,
    parameter int LOTE       = LOTE_PADRAO,
    parameter int LIMIAR     = LIMIAR_PADRAO,
    parameter int TIMEOUT    = TIMEOUT_PADRAO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             consumir,
    input  logic             reabastecer,
    output logic             ativar,
    output logic [WIDTH-1:0] qt_bandeja,
    output logic             vazia,
    output logic             erro_consumo,
    output logic             sem_estoque
);

    localparam logic [WIDTH:0]   LOTE_EXT = (WIDTH + 1)'(LOTE);
    localparam logic [WIDTH:0]   CAP_EXT  = (WIDTH + 1)'(CAPACIDADE);
    localparam logic [WIDTH-1:0] CAP_W    = WIDTH'(CAPACIDADE);
    localparam logic [WIDTH-1:0] LIM_W    = WIDTH'(LIMIAR);

    estado_t          estado;
    logic             grant;
    logic             ok;
    logic             dec;
    logic [WIDTH:0]   soma;
    logic [WIDTH:0]   soma_sat;
    logic [WIDTH-1:0] qt_prox;
    logic             atingiu;
    logic             limpar_to;
    logic             habilitar_to;

    // A grant only counts while a request is outstanding; ESPERA absorbs a stretched level.
    assign grant = (estado == PEDINDO) && reabastecer;
    assign ok    = (qt_bandeja != '0) || grant;
    assign dec   = consumir && ok;

    always_comb begin
        soma = {1'b0, qt_bandeja};
        if (grant) begin
            soma = soma + LOTE_EXT;
        end
        soma = soma - {{WIDTH{1'b0}}, dec};
    end

    generate
        if (WIDTH + 1 == 6) begin : g_sat_pkg
            assign soma_sat = saturar(soma, CAP_EXT);
        end else begin : g_sat_local
            assign soma_sat = (soma > CAP_EXT) ? CAP_EXT : soma;
        end
    endgenerate

    assign qt_prox = soma_sat[WIDTH-1:0];
    assign vazia   = (qt_bandeja == '0);

    assign limpar_to    = (estado != PEDINDO) || grant;
    assign habilitar_to = (estado == PEDINDO) && !grant;

    contador_timeout #(
        .LIMITE(TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .limpar   (limpar_to),
        .habilitar(habilitar_to),
        .atingiu  (atingiu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= NORMAL;
            qt_bandeja   <= CAP_W;
            ativar       <= 1'b0;
            erro_consumo <= 1'b0;
            sem_estoque  <= 1'b0;
        end else begin
            qt_bandeja   <= qt_prox;
            erro_consumo <= consumir && !ok;
            case (estado)
                NORMAL: begin
                    if (qt_prox <= LIM_W) begin
                        estado <= PEDINDO;
                        ativar <= 1'b1;
                    end
                end
                PEDINDO: begin
                    if (grant) begin
                        estado <= ESPERA;
                        ativar <= 1'b0;
                    end else if (atingiu) begin
                        estado      <= SEM_ESTOQUE;
                        ativar      <= 1'b0;
                        sem_estoque <= 1'b1;
                    end
                end
                ESPERA: begin
                    ativar <= 1'b0;
                    if (!reabastecer) begin
                        estado <= NORMAL;
                    end
                end
                SEM_ESTOQUE: begin
                    ativar      <= 1'b0;
                    sem_estoque <= 1'b1;
                end
                default: begin
                    estado <= NORMAL;
                    ativar <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bandeja_rolhas.sv
// Directed bench for the cork tray: drain, refill, simultaneous grant/consume, timeout, empty, reset.
module tb_bandeja_rolhas;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       consumir = 1'b0;
    logic       reabastecer = 1'b0;
    logic       ativar;
    logic [4:0] qt_bandeja;
    logic       vazia;
    logic       erro_consumo;
    logic       sem_estoque;

    int total = 0;
    int bad   = 0;

    bandeja_rolhas dut (
        .clk         (clk),
        .rst         (rst),
        .consumir    (consumir),
        .reabastecer (reabastecer),
        .ativar      (ativar),
        .qt_bandeja  (qt_bandeja),
        .vazia       (vazia),
        .erro_consumo(erro_consumo),
        .sem_estoque (sem_estoque)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, then settle just after the edge.
    task automatic step(input logic c, input logic r, input logic rs);
        consumir    = c;
        reabastecer = r;
        rst         = rs;
        @(posedge clk);
        #1;
        consumir    = 1'b0;
        reabastecer = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic consome(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset state, drain to threshold
        step(1'b0, 1'b0, 1'b1);
        chk("rst_qt", qt_bandeja, 25);
        chk("rst_ativar", ativar, 0);
        chk("rst_sem", sem_estoque, 0);
        chk("rst_vazia", vazia, 0);
        chk("rst_erro", erro_consumo, 0);
        consome(19);
        chk("t1_qt6", qt_bandeja, 6);
        chk("t1_ativar_lo", ativar, 0);
        consome(1);
        chk("t1_qt5", qt_bandeja, 5);
        chk("t1_ativar_hi", ativar, 1);

        // 2: stretched grant adds exactly one batch
        step(1'b0, 1'b1, 1'b0);
        chk("t2_qt_g1", qt_bandeja, 25);
        chk("t2_ativar_g1", ativar, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("t2_qt_g2", qt_bandeja, 25);
        step(1'b0, 1'b1, 1'b0);
        chk("t2_qt_g3", qt_bandeja, 25);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_qt_rel", qt_bandeja, 25);
        chk("t2_ativar_rel", ativar, 0);

        // 3: grant and consume together at threshold
        consome(20);
        chk("t3_qt5", qt_bandeja, 5);
        chk("t3_ativar", ativar, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_qt24", qt_bandeja, 24);
        chk("t3_erro", erro_consumo, 0);
        chk("t3_ativar_lo", ativar, 0);
        step(1'b0, 1'b0, 1'b0);

        // 4: dispenser silent for TIMEOUT cycles
        step(1'b0, 1'b0, 1'b1);
        consome(20);
        chk("t4_qt5", qt_bandeja, 5);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("t4_ativar_3", ativar, 1);
        chk("t4_sem_3", sem_estoque, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("t4_sem_4", sem_estoque, 1);
        chk("t4_ativar_4", ativar, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t4_qt4", qt_bandeja, 4);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_late_grant", qt_bandeja, 4);
        chk("t4_sem_sticky", sem_estoque, 1);

        // 5: consume on empty tray
        consome(4);
        chk("t5_qt0", qt_bandeja, 0);
        chk("t5_vazia", vazia, 1);
        chk("t5_erro_pre", erro_consumo, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_qt_hold", qt_bandeja, 0);
        chk("t5_erro", erro_consumo, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_erro_pulse", erro_consumo, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_rst_sem", sem_estoque, 0);
        chk("t4_rst_qt", qt_bandeja, 25);

        // 6: reset mid-request
        consome(22);
        chk("t6_qt3", qt_bandeja, 3);
        chk("t6_ativar", ativar, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t6_qt25", qt_bandeja, 25);
        chk("t6_ativar_lo", ativar, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_ativar_stay", ativar, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
